bus_write_monitor: RTL

Bus-side capture stage that sits directly downstream of the CPU bus master on the multiplexed E/RW/AS/AD bus. It samples the bus on the 8 MHz crystal clock and demultiplexes address and data. It pairs consecutive byte writes at A and A+1 into 16-bit word records and queues them in a FIFO, which the test bench or the sound-chip model reads back. It also counts incomplete (orphan) byte writes and raises an interrupt at a configurable FIFO level.

---
 rtl/bus_write_monitor.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bus_write_monitor.sv
// bus_write_monitor
//   Captures CPU byte writes from the multiplexed E/RW/AS/AD bus. Byte writes
//   to A and A+1 (low-byte increment wraps within the page) are paired into
//   16-bit word records. The records are queued in a show-ahead FIFO.
//   Unpaired byte writes are counted. An interrupt asserts at a FIFO level.
//
// Ports
//   XTAL_IN        8 MHz clock; all logic runs on its rising edge
//   RESET_IN       asynchronous, active-high reset
//   E_IN/RW/AS     bus strobes (RW: 0 = write, AS: active-high)
//   DATA_ADDR_LOW  multiplexed low address / data byte
//   AD_HIGH        high address byte
//   rd_en          pop the FIFO head (ignored when empty)
//   rd_data        FIFO head {addr[15:0], data[15:0]}, 0 when empty
//   empty/full/count  FIFO status
//   overflow       sticky: a word was dropped at full; ovf_clr clears it
//   orphan_count   saturating count of unpaired byte writes
//   irq            count >= IRQ_LEVEL
module bus_write_monitor #(
    parameter int DEPTH     = 8,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                     XTAL_IN,
    input  logic                     RESET_IN,
    input  logic                     E_IN,
    input  logic                     RW,
    input  logic                     AS,
    input  logic [7:0]               DATA_ADDR_LOW,
    input  logic [7:0]               AD_HIGH,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               orphan_count,
    output logic                     irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, HAVE_LO} state_t;

    // Word record as queued in the FIFO
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } word_t;

    // ---------------- input stage ----------------
    logic        s_E, s_RW, s_AS, p_E, p_RW;
    logic [7:0]  s_DAL, s_AD_HIGH;
    logic [15:0] lat_addr;

    always_ff @(posedge XTAL_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            s_E       <= 1'b0;
            s_RW      <= 1'b0;
            s_AS      <= 1'b0;
            s_DAL     <= '0;
            s_AD_HIGH <= '0;
            p_E       <= 1'b0;
            p_RW      <= 1'b0;
            lat_addr  <= '0;
        end else begin
            s_E       <= E_IN;
            s_RW      <= RW;
            s_AS      <= AS;
            s_DAL     <= DATA_ADDR_LOW;
            s_AD_HIGH <= AD_HIGH;
            p_E       <= s_E;
            p_RW      <= s_RW;
            if (s_AS)
                lat_addr <= {s_AD_HIGH, s_DAL};
        end
    end

    // A byte event needs s_RW=0 and a release needs s_RW=1, so the two
    // never coincide and a simple priority in the FSM is sufficient.
    logic byte_ev, rw_rel;
    assign byte_ev = s_E & ~p_E & ~s_RW;
    assign rw_rel  = s_RW & ~p_RW;

    // ---------------- pairing FSM ----------------
    state_t      state, state_nxt;
    logic [15:0] lo_addr;
    logic [7:0]  lo_data;
    logic        addr_match, push, orphan_inc, lo_load;
    word_t       push_word;

    // The partner address increments only the low byte (0x20FF pairs with 0x2000)
    assign addr_match = (lat_addr == {lo_addr[15:8], lo_addr[7:0] + 8'd1});
    assign push_word  = '{addr: lo_addr, data: {s_DAL, lo_data}};

    always_ff @(posedge XTAL_IN or posedge RESET_IN) begin
        if (RESET_IN) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (byte_ev) state_nxt = HAVE_LO;
            HAVE_LO: begin
                if (byte_ev)     state_nxt = addr_match ? IDLE : HAVE_LO;
                else if (rw_rel) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        orphan_inc = 1'b0;
        lo_load    = 1'b0;
        case (state)
            IDLE:    lo_load = byte_ev;
            HAVE_LO: begin
                if (byte_ev) begin
                    if (addr_match) begin
                        push = 1'b1;
                    end else begin
                        orphan_inc = 1'b1;
                        lo_load    = 1'b1;
                    end
                end else if (rw_rel) begin
                    orphan_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge XTAL_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            lo_addr      <= '0;
            lo_data      <= '0;
            orphan_count <= '0;
        end else begin
            if (lo_load) begin
                lo_addr <= lat_addr;
                lo_data <= s_DAL;
            end
            if (orphan_inc && orphan_count != 8'hFF)
                orphan_count <= orphan_count + 8'd1;
        end
    end

    // ---------------- FIFO ----------------
    word_t            mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];
    assign irq     = (count >= CW'(IRQ_LEVEL));

    always_ff @(posedge XTAL_IN) begin
        if (do_push)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge XTAL_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // set wins over clear
            if (push & full & ~do_pop) overflow <= 1'b1;
            else if (ovf_clr)          overflow <= 1'b0;
        end
    end

endmodule
